end_screen_fader: RTL and testbench
===================================

// Module: end_screen_fader
// PURPOSE
// Full-screen tile-map end screen (WIN smiley / LOSE frown) with frame-synchronous fade-in, eye blink, player
// acknowledge and fade-out. Sits beside the game renderer; the top-level muxes its RGB onto the VGA pins while busy=1.
// Pixel path is a 2-stage pipeline fed by the VGA timing generator's row/column/display_enable.
// Sequencing is driven by a once-per-frame tick. On acknowledge it issues a single-cycle restart_pulse to the game FSM.
// PARAMETERS
// SCREEN_WIDTH        640  visible columns
// SCREEN_HEIGHT       480  visible rows
// BLOCK_WIDTH         40   tile edge in pixels; map is SCREEN_WIDTH/BLOCK_WIDTH x SCREEN_HEIGHT/BLOCK_WIDTH tiles
// FADE_STEP_FRAMES    4    frames per brightness step (>=1)
// BLINK_PERIOD_FRAMES 30   frames per eye-blink half-period (>=1)
// MIN_HOLD_FRAMES     60   frames in HOLD before jump_button is accepted
// PORTS
// vga_clock      in   1   pixel clock; only clock
// reset          in   1   synchronous, active-high
// start          in   1   level; sampled each cycle in IDLE
// mode           in   1   1=WIN, 0=LOSE; latched on accepted start
// jump_button    in   1   asynchronous, active-high player button
// row            in   int current row from timing generator
// column         in   int current column from timing generator
// display_enable in   1   visible-area flag
// vga_red        out  4
// vga_green      out  4
// vga_blue       out  4
// busy           out  1   1 in any state except IDLE
// restart_pulse  out  1   one-cycle pulse on FADE_OUT->IDLE
// leds           out  10  [1:0] state, [5:2] level, [8:6] 0, [9] latched mode
// BEHAVIOUR
// - Reset: state=IDLE, level=0, all counters 0, mode_q=0, RGB=0, busy=0, restart_pulse=0, leds=0, sync FFs cleared.
// - frame_tick: registered 1-cycle pulse on the first cycle with row==SCREEN_HEIGHT && column==0 (once per frame).
// - jump_button: 2-FF synchroniser, then rising-edge detect -> jump_edge (1 cycle).
// - FSM (state encoding IDLE=0, FADE_IN=1, HOLD=2, FADE_OUT=3):
//   IDLE: start=1 -> FADE_IN next cycle, mode_q<=mode, level=0, step_cnt=0. start while busy is ignored.
//   FADE_IN: on frame_tick step_cnt++; at step_cnt==FADE_STEP_FRAMES-1, clear step_cnt and level++.
//     When level becomes 15 -> HOLD; hold_cnt=0, blink_cnt=0, blink_on=1.
//   HOLD: on frame_tick hold_cnt++, saturating at MIN_HOLD_FRAMES. blink_cnt counts frames; at
//     BLINK_PERIOD_FRAMES-1 it wraps to 0 and blink_on toggles. jump_edge with hold_cnt==MIN_HOLD_FRAMES -> FADE_OUT.
//     Earlier edges are dropped; they are not queued.
//   FADE_OUT: same step cadence, level-- per step. When level becomes 0 -> IDLE, with restart_pulse=1 on that
//     same cycle only. jump_edge is ignored.
//   Simultaneous frame_tick and jump_edge in HOLD: the transition wins; hold/blink updates are irrelevant.
// - Level changes only on frame_tick cycles, so brightness is constant within a visible frame.
// - Pixel pipeline:
//   S1 registers tx=column/BLOCK_WIDTH, ty=row/BLOCK_WIDTH, de.
//   S2 looks up the 2-bit tile code (0 bg, 1 fg, 2 eye) from the mode_q map and registers RGB.
//   Latency: 2 cycles from row/column/display_enable to RGB.
// - Maps are 16x12, row 0 at top. Eyes: code 2 at (tx,ty)=(5..6,3..4) and (9..10,3..4).
//   WIN mouth: code 1 at ty=8 tx=4..11, ty=7 tx=3 and 12. LOSE mouth: ty=7 tx=4..11, ty=8 tx=3 and 12. Rest code 0.
// - Base colour: fg WIN=(F,F,0), LOSE=(F,0,0); bg=(0,0,4). Code 2 is fg when blink_on=1 or state!=HOLD, else bg.
// - Output channel = (base*level)/15, truncated 4-bit, so a channel of 15 outputs exactly level.
// - RGB=0 when the delayed de=0 or state==IDLE. Tiles outside the map (tx>=16 or ty>=12) use bg.
// - Reset mid-operation aborts to IDLE in one cycle with no restart_pulse.
// TESTING
// (Bench params: FADE_STEP_FRAMES=1, BLINK_PERIOD_FRAMES=2, MIN_HOLD_FRAMES=3; frame_tick by driving row=480,col=0.)
// 1 reset held 3 cycles, then start=0 for 10 frames -> RGB=0, busy=0, leds=0, restart_pulse never 1.
// 2 start=1,mode=1 then 15 frame_ticks -> level steps 1..15, one per tick; HOLD after the 15th tick;
//   pixel (row=340,col=200) -> (F,F,0), (row=20,col=20) -> (0,0,4).
// 3 HOLD, mode=0: pixel at tile (5,3) alternates (F,0,0)/(0,0,4) every 2 frames; tile (4,7) -> (F,0,0).
// 4 jump pulse after 1 HOLD frame -> stays HOLD; after 3 frames -> FADE_OUT; 15 ticks later level=0,
//   restart_pulse high exactly 1 cycle, busy=0.
// 5 reset asserted mid-FADE_IN (level=7) -> next cycle state IDLE, level=0, RGB=0, no restart_pulse.
// 6 row/column/de stepped per cycle -> RGB follows with exactly 2-cycle latency; de=0 gives RGB=0.

Source files
------------

// File: rtl/end_screen_fader_if.sv
// rtl/end_screen_fader_if.sv - pixel bus between VGA timing generator and the end-screen fader
// Purpose: carries scan position and visible-area flag into the fader, and its RGB back out.
// Ports (signals):
//   row, column     scan position from the timing generator
//   display_enable  visible-area flag
//   vga_red/green/blue  4-bit colour channels produced by the fader
// Modports: master = timing side (drives position, reads colour), slave = fader.
interface end_screen_fader_if;
  int         row;
  int         column;
  logic       display_enable;
  logic [3:0] vga_red;
  logic [3:0] vga_green;
  logic [3:0] vga_blue;

  modport master (
    output row, column, display_enable,
    input  vga_red, vga_green, vga_blue
  );

  modport slave (
    input  row, column, display_enable,
    output vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/end_screen_fader.sv
// rtl/end_screen_fader.sv - tile-map WIN/LOSE end screen with fade-in, blink, acknowledge and fade-out
// Purpose: draws a 16x12 smiley/frown tile map, brightness sequenced once per frame.
// Ports:
//   vga_clock      pixel clock (only clock)
//   reset          synchronous, active-high
//   start          level, accepted in IDLE only
//   mode           1=WIN, 0=LOSE, latched on accepted start
//   jump_button    asynchronous player acknowledge
//   pix            pixel bus (row/column/display_enable in, RGB out), 2-cycle latency
//   busy           high in every state except IDLE
//   restart_pulse  one cycle on FADE_OUT->IDLE
//   leds           [1:0] state, [5:2] level, [8:6] 0, [9] latched mode
module end_screen_fader #(
  parameter int SCREEN_WIDTH        = 640,
  parameter int SCREEN_HEIGHT       = 480,
  parameter int BLOCK_WIDTH         = 40,
  parameter int FADE_STEP_FRAMES    = 4,
  parameter int BLINK_PERIOD_FRAMES = 30,
  parameter int MIN_HOLD_FRAMES     = 60
) (
  input  logic                vga_clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                jump_button,
  end_screen_fader_if.slave   pix,
  output logic                busy,
  output logic                restart_pulse,
  output logic [9:0]          leds
);

  localparam int MAP_W = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam int MAP_H = SCREEN_HEIGHT / BLOCK_WIDTH;
  localparam logic [15:0] STEP_LAST  = 16'(FADE_STEP_FRAMES - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_PERIOD_FRAMES - 1);
  localparam logic [15:0] HOLD_MAX   = 16'(MIN_HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [3:0]  level;
  logic [15:0] step_cnt, hold_cnt, blink_cnt;
  logic        blink_on, mode_q;

  // Frame tick: first cycle of the row just below the visible area.
  logic tick_cond, tick_seen, frame_tick;
  assign tick_cond = (pix.row == SCREEN_HEIGHT) && (pix.column == 0);

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      tick_seen  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      tick_seen  <= tick_cond;
      frame_tick <= tick_cond & ~tick_seen;
    end
  end

  // Button: two flops against metastability, third flop for edge detect.
  logic jb_s1, jb_s2, jb_s3, jump_edge;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      jb_s1 <= 1'b0;
      jb_s2 <= 1'b0;
      jb_s3 <= 1'b0;
    end else begin
      jb_s1 <= jump_button;
      jb_s2 <= jb_s1;
      jb_s3 <= jb_s2;
    end
  end

  assign jump_edge = jb_s2 & ~jb_s3;

  logic step_done;
  assign step_done = frame_tick && (step_cnt == STEP_LAST);

  // FSM: state register
  always_ff @(posedge vga_clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = FADE_IN;
      FADE_IN:  if (step_done && level == 4'd14) next_state = HOLD;
      HOLD:     if (jump_edge && hold_cnt == HOLD_MAX) next_state = FADE_OUT;
      FADE_OUT: if (step_done && level == 4'd1) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
    leds = {mode_q, 3'b000, level, state};
  end

  // Sequencing datapath: level, cadence counters, blink and latched mode.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      level         <= 4'd0;
      step_cnt      <= '0;
      hold_cnt      <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b0;
      mode_q        <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      restart_pulse <= (state == FADE_OUT) && (next_state == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            level    <= 4'd0;
            step_cnt <= '0;
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              level    <= level + 4'd1;
              if (level == 4'd14) begin
                hold_cnt  <= '0;
                blink_cnt <= '0;
                blink_on  <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end
        HOLD: begin
          // Leaving HOLD takes priority over a coincident frame tick.
          if (next_state == FADE_OUT) begin
            step_cnt <= '0;
          end else if (frame_tick) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 16'd1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 16'd1;
            end
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              level    <= level - 4'd1;
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tile map: 0 background, 1 foreground (mouth), 2 eye.
  function automatic logic [1:0] tile_code(input logic win, input int tx, input int ty);
    int bar_row, corner_row;
    bar_row    = win ? 8 : 7;
    corner_row = win ? 7 : 8;
    if ((ty == 3 || ty == 4) && (tx == 5 || tx == 6 || tx == 9 || tx == 10))
      return 2'd2;
    if (ty == bar_row && tx >= 4 && tx <= 11)
      return 2'd1;
    if (ty == corner_row && (tx == 3 || tx == 12))
      return 2'd1;
    return 2'd0;
  endfunction

  // (base*level)/15 truncated; full-scale channel tracks level exactly.
  function automatic logic [3:0] scale(input logic [3:0] base, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = 8'(base) * 8'(lvl);
    return 4'(prod / 8'd15);
  endfunction

  // Pixel stage 1: tile coordinates and delayed display enable.
  int   tx_q, ty_q;
  logic de_q;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      tx_q <= 0;
      ty_q <= 0;
      de_q <= 1'b0;
    end else begin
      tx_q <= pix.column / BLOCK_WIDTH;
      ty_q <= pix.row / BLOCK_WIDTH;
      de_q <= pix.display_enable;
    end
  end

  // Pixel stage 2: map lookup and colour.
  logic       in_map, use_fg;
  logic [1:0] code;
  logic [3:0] base_r, base_g, base_b;
  logic [3:0] red_q, green_q, blue_q;

  always_comb begin
    in_map = (tx_q >= 0) && (tx_q < MAP_W) && (ty_q >= 0) && (ty_q < MAP_H);
    code   = in_map ? tile_code(mode_q, tx_q, ty_q) : 2'd0;
    // Eyes close (show background) only during the off half of the blink in HOLD.
    use_fg = (code == 2'd1) || ((code == 2'd2) && (blink_on || state != HOLD));
    if (use_fg) begin
      base_r = 4'hF;
      base_g = mode_q ? 4'hF : 4'h0;
      base_b = 4'h0;
    end else begin
      base_r = 4'h0;
      base_g = 4'h0;
      base_b = 4'h4;
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset || !de_q || state == IDLE) begin
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
    end else begin
      red_q   <= scale(base_r, level);
      green_q <= scale(base_g, level);
      blue_q  <= scale(base_b, level);
    end
  end

  assign pix.vga_red   = red_q;
  assign pix.vga_green = green_q;
  assign pix.vga_blue  = blue_q;

endmodule

// File: tb/tb_end_screen_fader.sv
// tb/tb_end_screen_fader.sv - directed self-checking bench for end_screen_fader
module tb_end_screen_fader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, mode, jump_button, busy, restart_pulse;
  logic [9:0] leds;

  end_screen_fader_if pix_if();

  end_screen_fader #(
    .FADE_STEP_FRAMES(1), .BLINK_PERIOD_FRAMES(2), .MIN_HOLD_FRAMES(3)
  ) dut (
    .vga_clock(clk), .reset(reset), .start(start), .mode(mode),
    .jump_button(jump_button), .pix(pix_if), .busy(busy),
    .restart_pulse(restart_pulse), .leds(leds)
  );

  int tests = 0;
  int fails = 0;
  int rp_cnt = 0;

  logic [11:0] sb[$];
  logic pix_valid = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;

  // Model of the sequencer as seen from the stimulus.
  logic [1:0] m_state;
  logic [3:0] m_level;
  logic       m_mode, m_blink;
  int         m_hold, m_bcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    v1 <= pix_valid;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (restart_pulse === 1'b1) rp_cnt++;
    if (v2) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("rgb", {pix_if.vga_red, pix_if.vga_green, pix_if.vga_blue}, sb.pop_front());
    end
  end

  function automatic logic [11:0] exp_rgb(input int r, input int c, input logic d);
    int tx, ty;
    logic fg;
    logic [3:0] er, eg, eb;
    if (!d || m_state == 2'd0) return 12'h000;
    tx = c / 40;
    ty = r / 40;
    fg = 1'b0;
    if (tx < 16 && ty < 12) begin
      if ((ty == 3 || ty == 4) && (tx inside {5, 6, 9, 10}))
        fg = m_blink || (m_state != 2'd2);
      else if (m_mode)
        fg = (ty == 8 && tx >= 4 && tx <= 11) || (ty == 7 && (tx == 3 || tx == 12));
      else
        fg = (ty == 7 && tx >= 4 && tx <= 11) || (ty == 8 && (tx == 3 || tx == 12));
    end
    if (fg) begin
      er = m_level;
      eg = m_mode ? m_level : 4'h0;
      eb = 4'h0;
    end else begin
      er = 4'h0;
      eg = 4'h0;
      eb = 4'((4 * int'(m_level)) / 15);
    end
    return {er, eg, eb};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int c, input logic d);
    pix_if.row = r;
    pix_if.column = c;
    pix_if.display_enable = d;
  endtask

  task automatic pix(input int r, input int c, input logic d, input logic [11:0] exp);
    drive(r, c, d);
    pix_valid = 1'b1;
    sb.push_back(exp);
    cyc();
  endtask

  task automatic settle();
    pix_valid = 1'b0;
    drive(0, 0, 1'b0);
    repeat (3) cyc();
  endtask

  task automatic m_reset();
    m_state = 2'd0; m_level = 4'd0; m_mode = 1'b0; m_blink = 1'b0;
    m_hold = 0; m_bcnt = 0;
  endtask

  task automatic tick();
    drive(480, 0, 1'b0);
    cyc();
    drive(0, 0, 1'b0);
    cyc();
    cyc();
    case (m_state)
      2'd1: begin
        m_level++;
        if (m_level == 4'd15) begin
          m_state = 2'd2; m_hold = 0; m_bcnt = 0; m_blink = 1'b1;
        end
      end
      2'd2: begin
        if (m_hold < 3) m_hold++;
        if (m_bcnt == 1) begin m_bcnt = 0; m_blink = ~m_blink; end
        else m_bcnt++;
      end
      2'd3: begin
        m_level--;
        if (m_level == 4'd0) m_state = 2'd0;
      end
      default: ;
    endcase
  endtask

  task automatic jump();
    jump_button = 1'b1;
    repeat (4) cyc();
    jump_button = 1'b0;
    repeat (2) cyc();
    if (m_state == 2'd2 && m_hold == 3) m_state = 2'd3;
  endtask

  task automatic do_start(input logic md);
    start = 1'b1;
    mode = md;
    cyc();
    start = 1'b0;
    if (m_state == 2'd0) begin
      m_state = 2'd1; m_mode = md; m_level = 4'd0;
    end
  endtask

  task automatic chk_leds(input string tag);
    chk(tag, leds, {m_mode, 3'b000, m_level, m_state});
    chk({tag, "_busy"}, busy, m_state != 2'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; jump_button = 1'b0;
    drive(0, 0, 1'b0);
    m_reset();
    repeat (3) cyc();
    chk("reset_leds", leds, 10'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rgb", {pix_if.vga_red, pix_if.vga_green, pix_if.vga_blue}, 12'h000);
    chk("reset_rp", restart_pulse, 1'b0);
    reset = 1'b0;

    // Idle frames with start low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_leds("idle");
    end
    pix(100, 100, 1'b1, 12'h000);
    settle();

    // WIN fade-in, one level per tick
    do_start(1'b1);
    chk_leds("start_win");
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_leds("fade_in");
    end
    chk("hold_state", leds[1:0], 2'd2);

    // Back-to-back pixels: latency and de gating
    pix(340, 200, 1'b1, 12'hFF0);
    pix(20, 20, 1'b1, 12'h004);
    pix(120, 200, 1'b1, 12'hFF0);
    pix(130, 420, 1'b1, exp_rgb(130, 420, 1'b1));
    pix(300, 300, 1'b0, 12'h000);
    pix(300, 160, 1'b1, exp_rgb(300, 160, 1'b1));
    pix(479, 639, 1'b1, 12'h004);
    pix(100, 700, 1'b1, 12'h004);
    settle();

    // Early acknowledges are dropped
    jump();
    chk_leds("jump_hold0");
    tick();
    jump();
    chk_leds("jump_hold1");
    tick();
    tick();
    pix(120, 200, 1'b1, exp_rgb(120, 200, 1'b1));
    settle();
    jump();
    chk_leds("jump_accept");
    chk("fade_out_state", leds[1:0], 2'd3);

    for (int i = 0; i < 15; i++) begin
      tick();
      chk_leds("fade_out");
      if (m_level == 4'd8) begin
        pix(120, 200, 1'b1, 12'h880);
        settle();
      end
    end
    chk("restart_count", rp_cnt, 1);
    chk("end_busy", busy, 1'b0);
    chk("end_rp_low", restart_pulse, 1'b0);

    // LOSE hold: blink and mouth
    do_start(1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk_leds("lose_hold");
    start = 1'b1; mode = 1'b1;
    cyc();
    start = 1'b0;
    chk_leds("start_ignored");
    for (int f = 0; f < 4; f++) begin
      pix(120, 200, 1'b1, exp_rgb(120, 200, 1'b1));
      pix(280, 160, 1'b1, 12'hF00);
      pix(320, 120, 1'b1, 12'hF00);
      pix(340, 200, 1'b1, 12'h004);
      settle();
      tick();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_reset();
    chk_leds("abort_hold");

    // Reset mid fade-in at level 7
    do_start(1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk_leds("lvl7");
    pix(340, 200, 1'b1, 12'h770);
    pix(20, 20, 1'b1, 12'h001);
    settle();
    reset = 1'b1;
    cyc();
    m_reset();
    chk("abort_leds", leds, 10'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rp", restart_pulse, 1'b0);
    reset = 1'b0;
    pix(340, 200, 1'b1, 12'h000);
    settle();
    chk("abort_rgb", {pix_if.vga_red, pix_if.vga_green, pix_if.vga_blue}, 12'h000);
    chk("restart_total", rp_cnt, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
